// File: rtl/uart_tx_cfg.sv
// UART transmitter with run-time data length (5..MAX_DATA_BITS), parity and stop-bit count.
// Frame settings are captured on accept, so upstream may change its inputs while a frame is on the line.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT  = 87,
    parameter int MAX_DATA_BITS = 8
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Tx_DV,
    output logic                     o_Tx_Ready,
    input  logic [MAX_DATA_BITS-1:0] i_Tx_Byte,
    input  logic [3:0]               i_Data_Bits,
    input  logic [1:0]               i_Parity_Mode,
    input  logic                     i_Two_Stop,
    output logic                     o_Tx_Serial,
    output logic                     o_Tx_Active,
    output logic                     o_Tx_Done
);
    localparam int                  CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]          MAX_LEN  = 4'(MAX_DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic [3:0] clamp_len(input logic [3:0] req);
        if (req < 4'd5)
            return 4'd5;
        else if (req > MAX_LEN)
            return MAX_LEN;
        else
            return req;
    endfunction

    function automatic logic [MAX_DATA_BITS-1:0] mask_data(input logic [MAX_DATA_BITS-1:0] data,
                                                           input logic [3:0] len);
        logic [MAX_DATA_BITS-1:0] masked;
        for (int i = 0; i < MAX_DATA_BITS; i++)
            masked[i] = (i < int'(len)) ? data[i] : 1'b0;
        return masked;
    endfunction

    // Bits above the active length are already zero, so reducing the whole word is safe.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic [1:0] mode);
        case (mode)
            2'b01:   return ~^data;
            2'b10:   return ^data;
            default: return 1'b1;
        endcase
    endfunction

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [3:0]               idx, idx_nxt;
    logic                     stop_idx, stop_nxt;
    logic                     serial_nxt, done_nxt, shift_en;

    logic [MAX_DATA_BITS-1:0] shift_reg;
    logic [3:0]               len_sh;
    logic [1:0]               mode_sh;
    logic                     two_stop_sh;
    logic                     parity_sh;

    logic [3:0]               len_req;
    logic [MAX_DATA_BITS-1:0] data_req;
    logic                     accept, bit_end, last_data;

    assign len_req   = clamp_len(i_Data_Bits);
    assign data_req  = mask_data(i_Tx_Byte, len_req);
    assign accept    = i_Tx_DV && (state == IDLE);
    assign bit_end   = (cnt == CNT_LAST);
    assign last_data = (idx == len_sh - 4'd1);

    assign o_Tx_Ready  = (state == IDLE);
    assign o_Tx_Active = !o_Tx_Ready;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            stop_idx    <= 1'b0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Done   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            stop_idx    <= stop_nxt;
            o_Tx_Serial <= serial_nxt;
            o_Tx_Done   <= done_nxt;
        end
    end

    // Frame shadow: pure datapath, only meaningful between accept and the return to IDLE.
    always_ff @(posedge i_Clock) begin
        if (accept) begin
            shift_reg   <= data_req;
            len_sh      <= len_req;
            mode_sh     <= i_Parity_Mode;
            two_stop_sh <= i_Two_Stop;
            parity_sh   <= parity_bit(data_req, i_Parity_Mode);
        end else if (shift_en) begin
            shift_reg <= shift_reg >> 1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = START;
            START:   if (bit_end) state_nxt = DATA;
            DATA:    if (bit_end && last_data) state_nxt = (mode_sh != 2'b00) ? PARITY : STOP;
            PARITY:  if (bit_end) state_nxt = STOP;
            STOP:    if (bit_end && (stop_idx == two_stop_sh)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered-output next values: the line level for the coming bit is chosen at each bit end.
    always_comb begin
        cnt_nxt    = bit_end ? '0 : cnt + 1'b1;
        idx_nxt    = idx;
        stop_nxt   = stop_idx;
        serial_nxt = o_Tx_Serial;
        done_nxt   = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt    = '0;
                serial_nxt = !accept;
            end
            START: begin
                if (bit_end) begin
                    serial_nxt = shift_reg[0];
                    idx_nxt    = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (!last_data) begin
                        idx_nxt    = idx + 4'd1;
                        serial_nxt = shift_reg[1];
                        shift_en   = 1'b1;
                    end else if (mode_sh != 2'b00) begin
                        serial_nxt = parity_sh;
                    end else begin
                        serial_nxt = 1'b1;
                        stop_nxt   = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    serial_nxt = 1'b1;
                    stop_nxt   = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    serial_nxt = 1'b1;
                    if (stop_idx == two_stop_sh)
                        done_nxt = 1'b1;
                    else
                        stop_nxt = 1'b1;
                end
            end
            default: begin
                cnt_nxt    = '0;
                serial_nxt = 1'b1;
            end
        endcase
    end
endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with run-time frame format: 5 to MAX_DATA_BITS data bits, LSB first, with selectable parity (none/odd/even/mark) and one or two stop bits. It uses a ready/valid handshake so an upstream FIFO or packet formatter can stream frames back-to-back. It sits between the sensor-data formatter and the FPGA TX pin and is the drop-in successor for fixed 8N1 links.

## Interface
- CLKS_PER_BIT, 87, clocks per UART bit: f_clk / baud. Must be ≥ 2.
- MAX_DATA_BITS, 8, width of the data input; legal range 5..9.
- i_Clock  in  1  sole clock; all logic on the rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Tx_DV  in  1  frame valid; a frame is accepted on an edge where i_Tx_DV && o_Tx_Ready.
- o_Tx_Ready  out  1  high only in IDLE; the block can accept a frame.
- i_Tx_Byte  in  MAX_DATA_BITS  payload; bit 0 is sent first. Bits at or above the active data length are ignored.
- i_Data_Bits  in  4  data length. Values < 5 act as 5; values > MAX_DATA_BITS act as MAX_DATA_BITS.
- i_Parity_Mode  in  2  00 none, 01 odd, 10 even, 11 mark (parity bit always 1).
- i_Two_Stop  in  1  0 = one stop bit, 1 = two stop bits.
- o_Tx_Serial  out  1  serial line, registered; idle/mark = 1.
- o_Tx_Active  out  1  high while a frame is on the line.
- o_Tx_Done  out  1  one-clock pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Bit counter width is $clog2(CLKS_PER_BIT); data index width is 4; stop-bit index width is 1.
- **IDLE:**
  - Outputs: o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0.
  - On accept: latch the payload, the clamped data length N, the parity mode and the stop count into shadow registers. Serial<=0, Ready<=0, Active<=1, count<=0, go to START.
  - The shadow registers make input changes during a frame have no effect on that frame.
- **START:** after CLKS_PER_BIT clocks, serial<=data[0], index<=0, go to DATA.
- **DATA:** each bit lasts CLKS_PER_BIT clocks. At the end of a bit:
  - If index<N-1: index+1, serial<=data[index+1].
  - Otherwise, if parity mode ≠ none: serial<=parity, go to PARITY.
  - Otherwise: serial<=1, go to STOP.
- **Parity value** (computed over the N latched bits only):
  - odd: XNOR-reduce of the data bits, so that data+parity has an odd count of ones.
  - even: XOR-reduce.
  - mark: 1.
- **PARITY:** after CLKS_PER_BIT clocks, serial<=1, go to STOP.
- **STOP:** lasts 1 or 2 bit times. At the end of the last stop bit: serial stays 1, Done<=1, Ready<=1, Active<=0, go to IDLE.
- **o_Tx_Done** is registered and clears on the following edge. It is never asserted outside that single cycle.
- **Reset** (any state, including mid-frame), on the next edge:
  - State=IDLE, o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0, counters 0.
  - An aborted frame produces no Done pulse.
  - i_Tx_DV is ignored on a reset edge.

## Timing
- Accept edge k: the start bit drives low from edge k for exactly CLKS_PER_BIT clocks.
- Frame length F = (1 + N + P + S) × CLKS_PER_BIT clocks, where P∈{0,1} and S∈{1,2}. The line is low/data/parity/stop over edges k … k+F.
- At edge k+F: Done=1, Ready=1, Active=0. These hold for the cycle between edges k+F and k+F+1.
- The earliest next accept is edge k+F+1. Minimum inter-frame mark gap is therefore exactly 1 clock beyond the stop bits, and sustained throughput with i_Tx_DV held high is one frame per F+1 clocks.
- o_Tx_Active equals NOT o_Tx_Ready at all times after reset.
- Every bit boundary is exact: no cumulative drift, and every bit (start, data, parity, stop) is exactly CLKS_PER_BIT clocks.

## Test plan
All scenarios use CLKS_PER_BIT=4 and MAX_DATA_BITS=9.
- **8N1, 0x0A5:** line = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks (40 clocks). Done pulses once at clock 40. Ready is low for clocks 1–39 and high at clock 40.
- **7E2, 0x041 (N=7, mode 10, two stop):** bits = 0, 1,0,0,0,0,0,1, parity 0, 1,1, for 44 clocks. Then a single Done.
- **5O1, 0x1F7 (N=5, mode 01):** data 1,1,1,0,1 (upper bits ignored), parity 1, for 32 clocks. Repeat with i_Data_Bits=2 and expect an identical waveform (clamp to 5).
- **Back-to-back:** hold i_Tx_DV=1 with bytes 0x11, 0x22, 0x33 in 8N1, advancing a byte on each accept. Expect three frames, each start bit exactly 1 clock after the previous Done cycle, three Done pulses, and Active=NOT Ready throughout.
- **Mid-frame config change:** change i_Parity_Mode, i_Data_Bits and i_Tx_Byte at clock 10 of an 8N1 frame. The frame is unchanged (40 clocks, no parity). The next frame uses the new settings.
- **Reset at clock 13 of a frame:** on the next edge serial=1, Ready=1, Active=0, and no Done pulse follows. A subsequent 0x0A5 frame is bit-exact as in scenario 1.
